// File: rtl/m_stack_pkg.sv
// Shared definitions for the multi-channel LIFO stack: operation encoding
// and the width helpers used to size channel selects and occupancy counters.
package m_stack_pkg;

  // Operation code is formed as {push, pop}.
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // Counter must represent 0..depth inclusive, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/m_stack_ram.sv
// Single-port synchronous RAM with read-first behaviour and a registered
// read port that only updates on a read, so its output holds between pops.
module m_stack_ram #(
  parameter int WORD   = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD-1:0]   wdata,
  output logic [WORD-1:0]   rdata
);

  logic [WORD-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Reading the array here sees the pre-edge contents, giving read-first on replace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/m_stack_mc.sv
// Multi-channel LIFO: CH independent stacks of DEPTH words sharing one RAM,
// with per-channel occupancy counters, full/empty decode and sticky errors.
module m_stack_mc
  import m_stack_pkg::*;
#(
  parameter int WORD  = 16,
  parameter int DEPTH = 1024,
  parameter int CH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ch_width(CH)-1:0] ch_sel,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WORD-1:0]         data_i,
  input  logic                    clr_err,
  output logic [WORD-1:0]         data_o,
  output logic                    valid_o,
  output logic [CH-1:0]           is_full,
  output logic [CH-1:0]           is_empty,
  output logic [CH-1:0]           ovf,
  output logic [CH-1:0]           unf
);

  localparam int CH_W   = ch_width(CH);
  localparam int CNT_W  = cnt_width(DEPTH);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ADDR_W = $clog2(CH * DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]  cnt [CH];
  logic [CH_W-1:0]   ch_idx;
  logic [CNT_W-1:0]  cur_cnt;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              cur_full;
  logic              cur_empty;
  logic [1:0]        op;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              wr_en;
  logic              set_ovf;
  logic              set_unf;

  // A single-channel build has no real select bits; pin the index to 0.
  assign ch_idx    = (CH > 1) ? ch_sel : '0;
  assign cur_cnt   = cnt[ch_idx];
  assign cur_full  = (cur_cnt == FULL_CNT);
  assign cur_empty = (cur_cnt == '0);
  assign op        = {push, pop};
  assign addr      = ADDR_W'({ch_idx, idx});

  always_comb begin
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    nxt_cnt = cur_cnt;
    idx     = cur_cnt[IDX_W-1:0];
    case (op)
      OP_PUSH: begin
        if (cur_full) set_ovf = 1'b1;
        else begin
          wr_en   = 1'b1;
          nxt_cnt = cur_cnt + ONE;
        end
      end
      OP_POP: begin
        if (cur_empty) set_unf = 1'b1;
        else begin
          rd_en   = 1'b1;
          idx     = IDX_W'(cur_cnt - ONE);
          nxt_cnt = cur_cnt - ONE;
        end
      end
      OP_REPL: begin
        // Replace on an empty stack degrades to a push but still flags underflow.
        if (cur_empty) begin
          set_unf = 1'b1;
          wr_en   = 1'b1;
          nxt_cnt = ONE;
        end else begin
          rd_en = 1'b1;
          wr_en = 1'b1;
          idx   = IDX_W'(cur_cnt - ONE);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) cnt[c] <= '0;
      ovf     <= '0;
      unf     <= '0;
      valid_o <= 1'b0;
    end else begin
      cnt[ch_idx] <= nxt_cnt;
      if (set_ovf)      ovf[ch_idx] <= 1'b1;
      else if (clr_err) ovf[ch_idx] <= 1'b0;
      if (set_unf)      unf[ch_idx] <= 1'b1;
      else if (clr_err) unf[ch_idx] <= 1'b0;
      valid_o <= rd_en;
    end
  end

  always_comb begin
    is_full  = '0;
    is_empty = '0;
    for (int c = 0; c < CH; c++) begin
      is_full[c]  = (cnt[c] == FULL_CNT);
      is_empty[c] = (cnt[c] == '0);
    end
  end

  m_stack_ram #(
    .WORD   (WORD),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .re    (rd_en),
    .we    (wr_en),
    .addr  (addr),
    .wdata (data_i),
    .rdata (data_o)
  );

endmodule

// File: tb/tb_m_stack_mc.sv
// Self-checking bench for m_stack_mc (WORD=16, DEPTH=4, CH=2) against a
// queue-per-channel reference model of the stack behaviour.
module tb_m_stack_mc;

  localparam int WORD  = 16;
  localparam int DEPTH = 4;
  localparam int CH    = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [0:0]      ch_sel = '0;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic [WORD-1:0] data_i = '0;
  logic            clr_err = 1'b0;
  logic [WORD-1:0] data_o;
  logic            valid_o;
  logic [CH-1:0]   is_full;
  logic [CH-1:0]   is_empty;
  logic [CH-1:0]   ovf;
  logic [CH-1:0]   unf;

  // Reference model state.
  logic [WORD-1:0] stk [CH][$];
  logic [CH-1:0]   m_ovf = '0;
  logic [CH-1:0]   m_unf = '0;
  logic [WORD-1:0] m_data = '0;
  logic            m_valid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  m_stack_mc #(.WORD(WORD), .DEPTH(DEPTH), .CH(CH)) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_sel   (ch_sel),
    .push     (push),
    .pop      (pop),
    .data_i   (data_i),
    .clr_err  (clr_err),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .is_full  (is_full),
    .is_empty (is_empty),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] m_full();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (stk[i].size() == DEPTH);
    return r;
  endfunction

  function automatic logic [CH-1:0] m_empty();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (stk[i].size() == 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) stk[i].delete();
    m_ovf   = '0;
    m_unf   = '0;
    m_data  = '0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle's operation, let it take effect, then advance the model.
  task automatic step(input int c, input bit ps, input bit pp,
                      input logic [WORD-1:0] d, input bit clr);
    bit so;
    bit su;
    ch_sel  = c[0:0];
    push    = ps;
    pop     = pp;
    data_i  = d;
    clr_err = clr;
    @(posedge clk);
    #1;
    so = 1'b0;
    su = 1'b0;
    m_valid = 1'b0;
    if (ps && pp) begin
      if (stk[c].size() > 0) begin
        m_data = stk[c][stk[c].size()-1];
        stk[c][stk[c].size()-1] = d;
        m_valid = 1'b1;
      end else begin
        stk[c].push_back(d);
        su = 1'b1;
      end
    end else if (ps) begin
      if (stk[c].size() < DEPTH) stk[c].push_back(d);
      else so = 1'b1;
    end else if (pp) begin
      if (stk[c].size() > 0) begin
        m_data  = stk[c].pop_back();
        m_valid = 1'b1;
      end else su = 1'b1;
    end
    if (so) m_ovf[c] = 1'b1;
    else if (clr) m_ovf[c] = 1'b0;
    if (su) m_unf[c] = 1'b1;
    else if (clr) m_unf[c] = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (is_empty !== 2'b11) begin n_fail++; $display("FAIL reset_empty got %b want 11", is_empty); end
    n_tests++;
    if (is_full !== 2'b00) begin n_fail++; $display("FAIL reset_full got %b want 00", is_full); end
    n_tests++;
    if (data_o !== 16'h0 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_out got %h/%b want 0000/0", data_o, valid_o);
    end
    n_tests++;
    if (ovf !== 2'b00 || unf !== 2'b00) begin
      n_fail++; $display("FAIL reset_err got ovf=%b unf=%b want 00/00", ovf, unf);
    end
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 16'h0, 0);
    n_tests++;
    if (is_empty !== 2'b11 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL idle got empty=%b valid=%b want 11/0", is_empty, valid_o);
    end
  endtask

  task automatic test_push_pop_full();
    logic [WORD-1:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) step(0, 1, 0, vals[i], 0);
    n_tests++;
    if (is_full[0] !== 1'b1) begin n_fail++; $display("FAIL full0 got %b want 1", is_full[0]); end
    for (int i = 3; i >= 0; i--) begin
      step(0, 0, 1, 16'h0, 0);
      n_tests++;
      if (valid_o !== 1'b1 || data_o !== vals[i]) begin
        n_fail++; $display("FAIL pop_seq%0d got %h/%b want %h/1", i, data_o, valid_o, vals[i]);
      end
    end
    n_tests++;
    if (is_empty[0] !== 1'b1) begin n_fail++; $display("FAIL empty0 got %b want 1", is_empty[0]); end
  endtask

  task automatic test_overflow();
    step(0, 1, 0, 16'h1111, 0);
    step(0, 1, 0, 16'h2222, 0);
    step(0, 1, 0, 16'h3333, 0);
    step(0, 1, 0, 16'h4444, 0);
    step(0, 1, 0, 16'hDEAD, 0);
    n_tests++;
    if (ovf[0] !== 1'b1 || is_full[0] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got ovf=%b full=%b want 1/1", ovf[0], is_full[0]);
    end
    step(0, 0, 1, 16'h0, 0);
    n_tests++;
    if (data_o !== 16'h4444 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pop got %h/%b want 4444/1", data_o, valid_o);
    end
    step(0, 0, 0, 16'h0, 1);
    n_tests++;
    if (ovf[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", ovf[0]); end
    step(0, 0, 1, 16'h0, 0);
    n_tests++;
    if (data_o !== 16'h3333) begin n_fail++; $display("FAIL ovf_pop2 got %h want 3333", data_o); end
  endtask

  task automatic test_underflow();
    logic [WORD-1:0] held;
    held = m_data;
    step(1, 0, 1, 16'h0, 0);
    n_tests++;
    if (valid_o !== 1'b0 || unf[1] !== 1'b1 || data_o !== held) begin
      n_fail++; $display("FAIL unf_pop got v=%b unf=%b d=%h want 0/1/%h", valid_o, unf[1], data_o, held);
    end
    step(1, 1, 1, 16'h00AA, 0);
    n_tests++;
    if (is_empty[1] !== 1'b0 || unf[1] !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL unf_repl got e=%b unf=%b v=%b want 0/1/0", is_empty[1], unf[1], valid_o);
    end
    step(1, 0, 1, 16'h0, 1);
    n_tests++;
    if (data_o !== 16'h00AA || valid_o !== 1'b1 || unf[1] !== 1'b0 || is_empty[1] !== 1'b1) begin
      n_fail++; $display("FAIL unf_drain got d=%h v=%b unf=%b want 00aa/1/0", data_o, valid_o, unf[1]);
    end
  endtask

  task automatic test_replace();
    step(0, 1, 1, 16'h5555, 0);
    n_tests++;
    if (data_o !== 16'h2222 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL repl_out got %h/%b want 2222/1", data_o, valid_o);
    end
    n_tests++;
    if (is_empty[0] !== 1'b0 || is_full[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      n_fail++; $display("FAIL repl_flags got e=%b f=%b o=%b want 0/0/0", is_empty[0], is_full[0], ovf[0]);
    end
    step(0, 0, 1, 16'h0, 0);
    n_tests++;
    if (data_o !== 16'h5555) begin n_fail++; $display("FAIL repl_pop got %h want 5555", data_o); end
    step(0, 0, 1, 16'h0, 0);
    n_tests++;
    if (data_o !== 16'h1111 || is_empty[0] !== 1'b1) begin
      n_fail++; $display("FAIL repl_pop2 got %h e=%b want 1111/1", data_o, is_empty[0]);
    end
  endtask

  task automatic test_random();
    int c;
    int op;
    for (int i = 0; i < 400; i++) begin
      c  = $urandom_range(0, CH-1);
      op = $urandom_range(0, 3);
      step(c, op[1], op[0], WORD'($urandom), ($urandom_range(0, 7) == 0));
      n_tests++;
      if (valid_o !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid it%0d got %b want %b", i, valid_o, m_valid);
      end
      n_tests++;
      if (data_o !== m_data) begin
        n_fail++; $display("FAIL rnd_data it%0d got %h want %h", i, data_o, m_data);
      end
      n_tests++;
      if (is_full !== m_full() || is_empty !== m_empty()) begin
        n_fail++; $display("FAIL rnd_flags it%0d got f=%b e=%b want f=%b e=%b", i, is_full, is_empty, m_full(), m_empty());
      end
      n_tests++;
      if (ovf !== m_ovf || unf !== m_unf) begin
        n_fail++; $display("FAIL rnd_err it%0d got o=%b u=%b want o=%b u=%b", i, ovf, unf, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    step(0, 1, 0, 16'h00A0, 0);
    step(1, 1, 0, 16'h00B0, 0);
    step(0, 1, 0, 16'h00A1, 0);
    step(1, 1, 0, 16'h00B1, 0);
    step(0, 0, 1, 16'h0, 0);
    n_tests++;
    if (data_o !== m_data || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_pop got %h/%b want %h/1", data_o, valid_o, m_data);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (valid_o !== 1'b0 || is_empty !== 2'b11 || is_full !== 2'b00) begin
      n_fail++; $display("FAIL async_rst got v=%b e=%b f=%b want 0/11/00", valid_o, is_empty, is_full);
    end
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 1, 16'h0, 0);
    n_tests++;
    if (unf !== 2'b01 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL post_rst got unf=%b v=%b want 01/0", unf, valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop_full();
    test_overflow();
    test_underflow();
    test_replace();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
